hbm_load_scheduler: RTL and testbench

Per-lane HBM-to-SRAM load sequencer for the memory controller. Arbitrates round-robin among the `LANES` parallel lanes requesting tile loads into one of their `BANKS` SRAM controllers. Grants one lane at a time and paces HBM beats with a valid/ready handshake. Drives the per-lane, per-bank SRAM write enables and a shared row address, and reports per-lane completion.

---
 rtl/hbm_load_scheduler.sv | 105 ++++++++++
 tb/tb_hbm_load_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hbm_load_scheduler.sv
// hbm_load_scheduler: round-robin HBM-to-SRAM tile load sequencer across lanes and banks
module hbm_load_scheduler #(
  parameter int LANES  = 6,
  parameter int BANKS  = 8,
  parameter int ADDR_W = 8,
  parameter int BANK_W = 3
) (
  input  logic                      CLK_i,
  input  logic                      RST_i,
  input  logic [LANES-1:0]          req_i,
  input  logic [LANES*BANK_W-1:0]   req_bank_i,
  input  logic [LANES*ADDR_W-1:0]   req_addr_i,
  input  logic [LANES*ADDR_W-1:0]   req_len_i,
  input  logic                      hbm_valid_i,
  output logic                      hbm_ready_o,
  output logic [LANES-1:0]          gnt_o,
  output logic [LANES*BANKS-1:0]    sram_we_o,
  output logic [ADDR_W-1:0]         sram_addr_o,
  output logic [LANES-1:0]          done_o,
  output logic                      busy_o
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
  state_t state_q, state_d;
  logic [LW-1:0] ptr_q, ptr_d, g_q, g_d, sel;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [ADDR_W-1:0] addr_q, addr_d, len_q, len_d, cnt_q, cnt_d;
  logic found;
  int j;
  // First requester at or above ptr, wrapping modulo LANES
  always_comb begin
    found = 1'b0;
    sel = ptr_q;
    j = 0;
    for (int i = 0; i < LANES; i++) begin
      j = int'(ptr_q) + i;
      if (j >= LANES) j = j - LANES;
      if (!found && req_i[j]) begin
        found = 1'b1;
        sel = LW'(j);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    g_d = g_q;
    bank_d = bank_q;
    addr_d = addr_q;
    len_d = len_q;
    cnt_d = cnt_q;
    gnt_o = '0;
    hbm_ready_o = 1'b0;
    sram_we_o = '0;
    sram_addr_o = '0;
    done_o = '0;
    case (state_q)
      IDLE: if (found) begin
        g_d = sel;
        bank_d = req_bank_i[int'(sel)*BANK_W +: BANK_W];
        addr_d = req_addr_i[int'(sel)*ADDR_W +: ADDR_W];
        len_d = req_len_i[int'(sel)*ADDR_W +: ADDR_W];
        cnt_d = '0;
        state_d = XFER;
      end
      XFER: begin
        gnt_o[g_q] = 1'b1;
        hbm_ready_o = 1'b1;
        sram_addr_o = addr_q;
        if (hbm_valid_i) begin
          sram_we_o[int'(g_q)*BANKS + int'(bank_q)] = 1'b1;
          addr_d = addr_q + 1'b1;
          cnt_d = cnt_q + 1'b1;
          state_d = (cnt_q == len_q) ? DONE : XFER;
        end
      end
      DONE: begin
        done_o[g_q] = 1'b1;
        ptr_d = (g_q == LW'(LANES-1)) ? '0 : g_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign busy_o = (state_q != IDLE);
  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      state_q <= IDLE;
      ptr_q <= '0;
      g_q <= '0;
      bank_q <= '0;
      addr_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      g_q <= g_d;
      bank_q <= bank_d;
      addr_q <= addr_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_hbm_load_scheduler.sv
// tb_hbm_load_scheduler: scoreboard bench checking writes, grants, completion order and reset behaviour
module tb_hbm_load_scheduler;
  localparam int LANES = 6, BANKS = 8, ADDR_W = 8, BANK_W = 3;
  localparam int EW = LANES*BANKS + ADDR_W;
  logic CLK_i = 1'b0, RST_i = 1'b1;
  logic [LANES-1:0] req_i = '0;
  logic [LANES*BANK_W-1:0] req_bank_i = '0;
  logic [LANES*ADDR_W-1:0] req_addr_i = '0, req_len_i = '0;
  logic hbm_valid_i = 1'b0;
  logic hbm_ready_o, busy_o;
  logic [LANES-1:0] gnt_o, done_o;
  logic [LANES*BANKS-1:0] sram_we_o;
  logic [ADDR_W-1:0] sram_addr_o;
  int checks = 0, errors = 0;
  logic [EW-1:0] exp_q[$];

  hbm_load_scheduler #(.LANES(LANES), .BANKS(BANKS), .ADDR_W(ADDR_W), .BANK_W(BANK_W)) dut (
    .CLK_i(CLK_i), .RST_i(RST_i), .req_i(req_i), .req_bank_i(req_bank_i),
    .req_addr_i(req_addr_i), .req_len_i(req_len_i), .hbm_valid_i(hbm_valid_i),
    .hbm_ready_o(hbm_ready_o), .gnt_o(gnt_o), .sram_we_o(sram_we_o),
    .sram_addr_o(sram_addr_o), .done_o(done_o), .busy_o(busy_o)
  );

  always #5 CLK_i = ~CLK_i;

  function automatic logic [EW-1:0] wr_entry(int lane, int bank, int addr);
    logic [LANES*BANKS-1:0] we;
    we = '0;
    we[lane*BANKS + bank] = 1'b1;
    return {we, ADDR_W'(addr)};
  endfunction

  // Every observed SRAM write must match the oldest expected write
  always @(negedge CLK_i) begin
    logic [EW-1:0] e;
    if (|sram_we_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected we=%h addr=%h", sram_we_o, sram_addr_o);
      end else begin
        e = exp_q.pop_front();
        if ({sram_we_o, sram_addr_o} !== e) begin
          errors++;
          $display("FAIL write_match got we=%h addr=%h want we=%h addr=%h",
                   sram_we_o, sram_addr_o, e[EW-1:ADDR_W], e[ADDR_W-1:0]);
        end
      end
    end
  end

  task automatic set_lane(int lane, int bank, int addr, int len);
    req_bank_i[lane*BANK_W +: BANK_W] = BANK_W'(bank);
    req_addr_i[lane*ADDR_W +: ADDR_W] = ADDR_W'(addr);
    req_len_i[lane*ADDR_W +: ADDR_W] = ADDR_W'(len);
  endtask

  task automatic do_xfer(input int lane, input int bank, input int addr, input int len,
                         input bit [31:0] vpat, input int npat, input bit scramble,
                         output int done_at, output int gcnt);
    logic [LANES-1:0] oh;
    oh = '0;
    oh[lane] = 1'b1;
    set_lane(lane, bank, addr, len);
    req_i[lane] = 1'b1;
    hbm_valid_i = 1'b0;
    for (int k = 0; k <= len; k++) exp_q.push_back(wr_entry(lane, bank, (addr + k) % 256));
    done_at = -1;
    gcnt = 0;
    for (int c = 1; c <= 600 && done_at < 0; c++) begin
      @(posedge CLK_i); #1;
      hbm_valid_i = (c - 1 < npat) ? vpat[c-1] : 1'b1;
      if (scramble && c == 2) set_lane(lane, (bank + 3) % BANKS, (addr + 77) % 256, 0);
      @(negedge CLK_i);
      if (done_o != '0) begin
        done_at = c;
        checks++;
        if (done_o !== oh) begin
          errors++;
          $display("FAIL done_lane got %b want %b", done_o, oh);
        end
        req_i[lane] = 1'b0;
      end else if (gnt_o === oh && hbm_ready_o === 1'b1) gcnt++;
    end
    if (done_at < 0) begin
      checks++; errors++;
      $display("FAIL done_timeout lane %0d", lane);
    end
    @(posedge CLK_i); #1;
    hbm_valid_i = 1'b0;
    @(negedge CLK_i);
    checks++;
    if (done_o !== '0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL done_single_pulse got done=%b busy=%b want 0 0", done_o, busy_o);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL writes_missing got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    RST_i = 1'b1;
    hbm_valid_i = 1'b1;
    repeat (2) @(posedge CLK_i);
    @(negedge CLK_i);
    checks++;
    if ({gnt_o, done_o, sram_we_o, hbm_ready_o, busy_o, sram_addr_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs gnt=%b done=%b we=%h rdy=%b busy=%b addr=%h want all 0",
               gnt_o, done_o, sram_we_o, hbm_ready_o, busy_o, sram_addr_o);
    end
    @(posedge CLK_i); #1;
    RST_i = 1'b0;
    @(negedge CLK_i);
    checks++;
    if (hbm_ready_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_ready got rdy=%b busy=%b want 0 0", hbm_ready_o, busy_o);
    end
    @(posedge CLK_i); #1;
    hbm_valid_i = 1'b0;
  endtask

  task automatic test_single();
    int d, g;
    do_xfer(2, 5, 'h10, 3, '0, 0, 1'b0, d, g);
    checks++;
    if (d != 5) begin errors++; $display("FAIL single_done_cycle got %0d want 5", d); end
    checks++;
    if (g != 4) begin errors++; $display("FAIL single_gnt_cycles got %0d want 4", g); end
  endtask

  task automatic test_gaps();
    int d, g;
    do_xfer(0, 3, 'h50, 3, 32'b1011001, 7, 1'b0, d, g);
    checks++;
    if (d != 8) begin errors++; $display("FAIL gaps_done_cycle got %0d want 8", d); end
  endtask

  task automatic test_wrap();
    int d, g;
    do_xfer(4, 1, 'hFE, 3, '0, 0, 1'b0, d, g);
    checks++;
    if (d != 5) begin errors++; $display("FAIL wrap_done_cycle got %0d want 5", d); end
  endtask

  task automatic test_input_change();
    int d, g;
    do_xfer(5, 1, 'h20, 3, '0, 0, 1'b1, d, g);
    checks++;
    if (d != 5) begin errors++; $display("FAIL change_done_cycle got %0d want 5", d); end
  endtask

  task automatic test_contend();
    int got[$];
    int want[7] = '{0, 1, 2, 3, 4, 5, 0};
    bit rearm = 1'b0;
    RST_i = 1'b1;
    @(posedge CLK_i); #1;
    RST_i = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      set_lane(l, l, l*16, 0);
      exp_q.push_back(wr_entry(l, l, l*16));
    end
    exp_q.push_back(wr_entry(0, 7, 'h80));
    req_i = '1;
    hbm_valid_i = 1'b1;
    for (int c = 0; c < 200 && got.size() < 7; c++) begin
      @(negedge CLK_i);
      if (rearm) begin
        set_lane(0, 7, 'h80, 0);
        req_i[0] = 1'b1;
        rearm = 1'b0;
      end
      for (int l = 0; l < LANES; l++) if (done_o[l]) begin
        got.push_back(l);
        req_i[l] = 1'b0;
        if (l == 0 && got.size() == 1) rearm = 1'b1;
      end
    end
    checks++;
    if (got.size() != 7) begin errors++; $display("FAIL contend_count got %0d want 7", got.size()); end
    for (int i = 0; i < 7 && i < got.size(); i++) begin
      checks++;
      if (got[i] != want[i]) begin
        errors++;
        $display("FAIL contend_order idx %0d got lane %0d want lane %0d", i, got[i], want[i]);
      end
    end
    @(posedge CLK_i); #1;
    hbm_valid_i = 1'b0;
    req_i = '0;
    @(posedge CLK_i); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL contend_writes got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    int d, g;
    set_lane(1, 2, 'h40, 7);
    exp_q.push_back(wr_entry(1, 2, 'h40));
    exp_q.push_back(wr_entry(1, 2, 'h41));
    req_i[1] = 1'b1;
    hbm_valid_i = 1'b1;
    repeat (3) @(posedge CLK_i);
    #1;
    hbm_valid_i = 1'b0;
    RST_i = 1'b1;
    req_i = '0;
    @(posedge CLK_i); #1;
    RST_i = 1'b0;
    @(negedge CLK_i);
    checks++;
    if ({gnt_o, done_o, sram_we_o, hbm_ready_o, busy_o, sram_addr_o} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs gnt=%b done=%b we=%h rdy=%b busy=%b want all 0",
               gnt_o, done_o, sram_we_o, hbm_ready_o, busy_o);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK_i);
      checks++;
      if (done_o !== '0) begin errors++; $display("FAIL midreset_no_done got %b want 0", done_o); end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_writes got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
    do_xfer(3, 6, 'h33, 1, '0, 0, 1'b0, d, g);
    checks++;
    if (d != 3) begin errors++; $display("FAIL postreset_done_cycle got %0d want 3", d); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_gaps();
    test_wrap();
    test_input_change();
    test_contend();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
